// File: rtl/esc_pkg.sv
// Shared types and constants for the ESC arming/slew sequencer.
package esc_pkg;

  typedef enum logic [1:0] {
    DISARMED = 2'd0,
    ARMING   = 2'd1,
    RUN      = 2'd2,
    UPDATE   = 2'd3
  } esc_state_t;

  localparam int NUM_MOTORS = 4;
  localparam int SPD_W      = 11;
  localparam int IDX_W      = $clog2(NUM_MOTORS);

  localparam logic [SPD_W-1:0] SPD_CEIL = 11'h7FF;

  // Keeps a requested speed inside [lo, SPD_CEIL]; never lets a motor idle below lo.
  function automatic logic [SPD_W-1:0] clamp_spd(input logic [SPD_W-1:0] spd,
                                                 input logic [SPD_W-1:0] lo);
    logic [SPD_W-1:0] r;
    r = spd;
    if (r < lo) r = lo;
    if (r > SPD_CEIL) r = SPD_CEIL;
    return r;
  endfunction

endpackage

// File: rtl/esc_slew_step.sv
// Combinational slew limiter: moves cur toward tgt by at most step.
module esc_slew_step
  import esc_pkg::*;
(
  input  logic [SPD_W-1:0] cur,
  input  logic [SPD_W-1:0] tgt,
  input  logic [SPD_W-1:0] step,
  output logic [SPD_W-1:0] nxt
);

  logic signed [SPD_W:0] diff;
  logic signed [SPD_W:0] step_s;

  // One extra bit makes the difference signed; both operands stay in range so no wrap.
  always_comb begin
    diff   = $signed({1'b0, tgt}) - $signed({1'b0, cur});
    step_s = $signed({1'b0, step});
    if (diff > step_s)
      nxt = cur + step;
    else if (diff < -step_s)
      nxt = cur - step;
    else
      nxt = tgt;
  end

endmodule

// File: rtl/esc_sequencer.sv
// Arms four ESC channels and slew-limits their speed commands, one motor per cycle.
//
//   state    | meaning
//   ---------+--------------------------------------------------------
//   DISARMED | all speeds 0, waiting for frame with arm_req
//   ARMING   | speeds 0, counting ARM_FRAMES frames before spinning up
//   RUN      | idle spin or flying, commands accepted, waiting for frame
//   UPDATE   | stepping motor idx toward its target, one per cycle
module esc_sequencer
  import esc_pkg::*;
#(
  parameter int               ARM_FRAMES = 16,
  parameter logic [SPD_W-1:0] MIN_SPEED  = 11'd100,
  parameter logic [SPD_W-1:0] MAX_STEP   = 11'd64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             frame,
  input  logic             arm_req,
  input  logic             cmd_vld,
  output logic             cmd_rdy,
  input  logic [SPD_W-1:0] cmd_spd0,
  input  logic [SPD_W-1:0] cmd_spd1,
  input  logic [SPD_W-1:0] cmd_spd2,
  input  logic [SPD_W-1:0] cmd_spd3,
  output logic [SPD_W-1:0] spd0,
  output logic [SPD_W-1:0] spd1,
  output logic [SPD_W-1:0] spd2,
  output logic [SPD_W-1:0] spd3,
  output logic             armed,
  output logic             busy
);

  localparam int CNT_W = $clog2(ARM_FRAMES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ARM_FRAMES - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_MOTORS - 1);

  esc_state_t       state;
  logic [CNT_W-1:0] frame_cnt;
  logic [IDX_W-1:0] idx;
  logic [SPD_W-1:0] tgt_q   [NUM_MOTORS];
  logic [SPD_W-1:0] cur_q   [NUM_MOTORS];
  logic [SPD_W-1:0] cmd_vec [NUM_MOTORS];
  logic [SPD_W-1:0] slew_nxt;

  assign cmd_vec[0] = cmd_spd0;
  assign cmd_vec[1] = cmd_spd1;
  assign cmd_vec[2] = cmd_spd2;
  assign cmd_vec[3] = cmd_spd3;

  assign spd0 = cur_q[0];
  assign spd1 = cur_q[1];
  assign spd2 = cur_q[2];
  assign spd3 = cur_q[3];

  // Single shared slew unit; idx selects which motor it serves this cycle.
  esc_slew_step u_slew (
    .cur  (cur_q[idx]),
    .tgt  (tgt_q[idx]),
    .step (MAX_STEP),
    .nxt  (slew_nxt)
  );

  // Sequencer FSM with registered status outputs; disarm in RUN/UPDATE beats everything.
  always_ff @(posedge clk) begin
    if (rst || (!arm_req && (state == RUN || state == UPDATE))) begin
      state     <= DISARMED;
      frame_cnt <= '0;
      idx       <= '0;
      armed     <= 1'b0;
      busy      <= 1'b0;
      cmd_rdy   <= 1'b0;
      for (int i = 0; i < NUM_MOTORS; i++) begin
        cur_q[i] <= '0;
        tgt_q[i] <= '0;
      end
    end else begin
      case (state)
        DISARMED: begin
          if (frame && arm_req) begin
            state     <= ARMING;
            frame_cnt <= '0;
          end
        end
        ARMING: begin
          if (!arm_req) begin
            state <= DISARMED;
          end else if (frame) begin
            if (frame_cnt == CNT_LAST) begin
              state     <= RUN;
              armed     <= 1'b1;
              cmd_rdy   <= 1'b1;
              frame_cnt <= '0;
              for (int i = 0; i < NUM_MOTORS; i++) begin
                cur_q[i] <= MIN_SPEED;
                tgt_q[i] <= MIN_SPEED;
              end
            end else begin
              frame_cnt <= frame_cnt + 1'b1;
            end
          end
        end
        RUN: begin
          if (cmd_vld) begin
            for (int i = 0; i < NUM_MOTORS; i++)
              tgt_q[i] <= clamp_spd(cmd_vec[i], MIN_SPEED);
          end
          if (frame) begin
            state   <= UPDATE;
            idx     <= '0;
            busy    <= 1'b1;
            cmd_rdy <= 1'b0;
          end
        end
        UPDATE: begin
          cur_q[idx] <= slew_nxt;
          idx        <= idx + 1'b1;
          if (idx == IDX_LAST) begin
            state   <= RUN;
            busy    <= 1'b0;
            cmd_rdy <= 1'b1;
          end
        end
        default: state <= DISARMED;
      endcase
    end
  end

endmodule

// File: tb/tb_esc_sequencer.sv
// Directed + randomized bench for esc_sequencer against a frame-level speed model.
module tb_esc_sequencer;

  logic        clk = 1'b0;
  logic        rst, frame, arm_req, cmd_vld, cmd_rdy, armed, busy;
  logic [10:0] cmd_spd0, cmd_spd1, cmd_spd2, cmd_spd3;
  logic [10:0] spd0, spd1, spd2, spd3;
  logic [10:0] cmd_a [4];
  logic [10:0] spd_a [4];

  int total = 0;
  int bad   = 0;
  int cur_m [4];
  int tgt_m [4];

  localparam int MIN_S = 100;
  localparam int STEP  = 64;

  assign cmd_spd0 = cmd_a[0];
  assign cmd_spd1 = cmd_a[1];
  assign cmd_spd2 = cmd_a[2];
  assign cmd_spd3 = cmd_a[3];
  assign spd_a[0] = spd0;
  assign spd_a[1] = spd1;
  assign spd_a[2] = spd2;
  assign spd_a[3] = spd3;

  always #5 clk = ~clk;

  esc_sequencer dut (
    .clk(clk), .rst(rst), .frame(frame), .arm_req(arm_req),
    .cmd_vld(cmd_vld), .cmd_rdy(cmd_rdy),
    .cmd_spd0(cmd_spd0), .cmd_spd1(cmd_spd1), .cmd_spd2(cmd_spd2), .cmd_spd3(cmd_spd3),
    .spd0(spd0), .spd1(spd1), .spd2(spd2), .spd3(spd3),
    .armed(armed), .busy(busy)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_accept();
    for (int i = 0; i < 4; i++)
      tgt_m[i] = (int'(cmd_a[i]) < MIN_S) ? MIN_S : int'(cmd_a[i]);
  endtask

  task automatic model_frame();
    for (int i = 0; i < 4; i++) begin
      if (tgt_m[i] > cur_m[i])
        cur_m[i] += (tgt_m[i] - cur_m[i] < STEP) ? tgt_m[i] - cur_m[i] : STEP;
      else if (tgt_m[i] < cur_m[i])
        cur_m[i] -= (cur_m[i] - tgt_m[i] < STEP) ? cur_m[i] - tgt_m[i] : STEP;
    end
  endtask

  task automatic model_zero();
    for (int i = 0; i < 4; i++) begin
      cur_m[i] = 0;
      tgt_m[i] = 0;
    end
  endtask

  task automatic check_all_spd(input string tag);
    for (int i = 0; i < 4; i++)
      check($sformatf("%s_spd%0d", tag, i), spd_a[i], cur_m[i]);
  endtask

  // Frame pulse in RUN; motor i shows its new value from t+2+i.
  task automatic do_frame(input bit with_cmd);
    int old [4];
    old = cur_m;
    if (with_cmd) begin
      cmd_vld = 1'b1;
      model_accept();
    end
    model_frame();
    frame = 1'b1;
    tick();
    frame   = 1'b0;
    cmd_vld = 1'b0;
    check("busy_t1", busy, 1);
    check("rdy_t1", cmd_rdy, 0);
    for (int k = 2; k <= 5; k++) begin
      tick();
      for (int i = 0; i < 4; i++)
        check($sformatf("spd%0d_t%0d", i, k), spd_a[i], (i <= k - 2) ? cur_m[i] : old[i]);
      check($sformatf("busy_t%0d", k), busy, (k <= 4) ? 1 : 0);
    end
    check("rdy_t5", cmd_rdy, 1);
  endtask

  task automatic do_accept();
    check("rdy_before_accept", cmd_rdy, 1);
    cmd_vld = 1'b1;
    tick();
    cmd_vld = 1'b0;
    model_accept();
  endtask

  task automatic do_arm();
    arm_req = 1'b1;
    for (int n = 1; n <= 17; n++) begin
      frame = 1'b1;
      tick();
      frame = 1'b0;
      tick();
      tick();
      if (n == 16) begin
        check("armed_after16", armed, 0);
        check("spd0_after16", spd0, 0);
      end
    end
    for (int i = 0; i < 4; i++) begin
      cur_m[i] = MIN_S;
      tgt_m[i] = MIN_S;
    end
    check("armed_after17", armed, 1);
    check("rdy_after17", cmd_rdy, 1);
    check_all_spd("arm");
  endtask

  initial begin
    int exp_up [4];
    int exp_dn [4];
    exp_up = '{164, 228, 292, 300};
    exp_dn = '{236, 172, 108, 100};
    rst = 1'b1; frame = 1'b0; arm_req = 1'b0; cmd_vld = 1'b0;
    for (int i = 0; i < 4; i++) cmd_a[i] = '0;
    model_zero();

    // Reset
    tick(); tick();
    rst = 1'b0;
    tick();
    check_all_spd("reset");
    check("reset_armed", armed, 0);
    check("reset_busy", busy, 0);
    check("reset_rdy", cmd_rdy, 0);

    // Arming
    do_arm();

    // Ramp up motor 0
    cmd_a[0] = 11'd300;
    do_accept();
    for (int f = 0; f < 4; f++) begin
      do_frame(1'b0);
      check($sformatf("ramp_up_%0d", f), spd0, exp_up[f]);
      check($sformatf("ramp_up_spd1_%0d", f), spd1, MIN_S);
    end

    // Ramp down with clamp to floor
    cmd_a[0] = 11'd0;
    do_accept();
    for (int f = 0; f < 4; f++) begin
      do_frame(1'b0);
      check($sformatf("ramp_dn_%0d", f), spd0, exp_dn[f]);
    end
    do_frame(1'b0);
    check("ramp_dn_hold", spd0, 100);

    // Command and frame in the same cycle
    cmd_a[1] = 11'd500;
    do_frame(1'b1);
    check("collide_spd1", spd1, 164);

    // cmd_vld during busy with a value that must be ignored, then released
    frame = 1'b1;
    tick();
    frame = 1'b0;
    cmd_a[2] = 11'd2000;
    cmd_vld  = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      check($sformatf("busy_rdy_t%0d", k + 1), cmd_rdy, 0);
      tick();
    end
    cmd_vld = 1'b0;
    tick();
    model_frame();
    check("rdy_back_t5", cmd_rdy, 1);
    check_all_spd("ignore_busy");
    // Held command across busy: accepted once cmd_rdy returns
    cmd_a[2] = 11'd900;
    frame    = 1'b1;
    tick();
    frame    = 1'b0;
    cmd_vld  = 1'b1;
    model_frame();
    for (int k = 1; k <= 4; k++) begin
      check($sformatf("held_rdy_t%0d", k), cmd_rdy, 0);
      tick();
    end
    check("held_rdy_t5", cmd_rdy, 1);
    tick();
    cmd_vld = 1'b0;
    model_accept();
    do_frame(1'b0);
    check("held_spd2", spd2, cur_m[2]);

    // Disarm mid-UPDATE
    frame = 1'b1;
    tick();
    frame = 1'b0;
    tick();
    arm_req = 1'b0;
    tick();
    model_zero();
    check_all_spd("disarm");
    check("disarm_armed", armed, 0);
    check("disarm_busy", busy, 0);
    check("disarm_rdy", cmd_rdy, 0);
    frame = 1'b1;
    tick();
    frame = 1'b0;
    tick(); tick();
    check("disarm_stay_armed", armed, 0);
    check_all_spd("disarm_stay");

    // Randomized command/frame traffic
    do_arm();
    for (int r = 0; r < 40; r++) begin
      repeat ($urandom_range(0, 3)) tick();
      if ($urandom_range(0, 1) == 1) begin
        for (int i = 0; i < 4; i++) cmd_a[i] = 11'($urandom_range(0, 2047));
        if ($urandom_range(0, 1) == 1) do_accept();
        else do_frame(1'b1);
      end else begin
        do_frame(1'b0);
      end
    end

    // Reset mid-UPDATE
    frame = 1'b1;
    tick();
    frame = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    model_zero();
    check_all_spd("rst_mid");
    check("rst_mid_armed", armed, 0);
    check("rst_mid_busy", busy, 0);
    check("rst_mid_rdy", cmd_rdy, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
